// File: rtl/jk_bank_arbiter.sv
// Arbitrated JK storage bank. Grants one requester per cycle and applies its J/K command to the addressed cell on the next edge.
// Grant lands one cycle after the request; Q and upd update one cycle after that. Requesters hold req until gnt; JK_ARB_FIXED_PRIO_EN selects fixed priority.
module jk_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      J,
  input  logic [N_REQ-1:0]      K,
  input  logic [N_REQ*AW-1:0]   addr,
  output logic [N_REQ-1:0]      gnt,
  output logic                  upd,
  output logic [AW-1:0]         upd_addr,
  output logic [WIDTH-1:0]      Q,
  output logic [WIDTH-1:0]      Qm
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic             w_found;
  logic [PW-1:0]    w_win;

  logic             w_sel_j;
  logic             w_sel_k;
  logic [AW-1:0]    w_sel_addr;

  logic             r_cmd_vld;
  logic             r_cmd_j;
  logic             r_cmd_k;
  logic [AW-1:0]    r_cmd_addr;

  logic             r_upd;
  logic [AW-1:0]    r_upd_addr;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;

  // Last cycle's winner sits out one cycle so its next command is never taken early.
  assign w_elig = req & ~r_gnt;

`ifdef JK_ARB_FIXED_PRIO_EN
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_found = 1'b1;
        w_win   = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] r_ptr;

  always_comb begin
    logic [PW:0]   v_sum;
    logic [PW-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_sum   = '0;
    v_idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      v_sum = {1'b0, r_ptr} + (PW+1)'(off);
      if (v_sum >= (PW+1)'(N_REQ)) begin
        v_sum = v_sum - (PW+1)'(N_REQ);
      end
      v_idx = v_sum[PW-1:0];
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    end
  end
`endif

  assign w_gnt_nxt = w_found ? (N_REQ'(1) << w_win) : '0;

  always_comb begin
    w_sel_j    = 1'b0;
    w_sel_k    = 1'b0;
    w_sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_nxt[i]) begin
        w_sel_j    = J[i];
        w_sel_k    = K[i];
        w_sel_addr = addr[i*AW +: AW];
      end
    end
  end

  // Out-of-range addresses match no cell, so the bank simply holds.
  always_comb begin
    w_q_nxt = r_q;
    for (int b = 0; b < WIDTH; b++) begin
      if (r_cmd_vld && (r_cmd_addr == AW'(b))) begin
        case ({r_cmd_j, r_cmd_k})
          2'b10:   w_q_nxt[b] = 1'b1;
          2'b01:   w_q_nxt[b] = 1'b0;
          2'b11:   w_q_nxt[b] = ~r_q[b];
          default: w_q_nxt[b] = r_q[b];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= '0;
      r_cmd_vld  <= 1'b0;
      r_cmd_j    <= 1'b0;
      r_cmd_k    <= 1'b0;
      r_cmd_addr <= '0;
      r_upd      <= 1'b0;
      r_upd_addr <= '0;
      r_q        <= '0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_cmd_vld <= w_found;
      if (w_found) begin
        r_cmd_j    <= w_sel_j;
        r_cmd_k    <= w_sel_k;
        r_cmd_addr <= w_sel_addr;
      end
      r_upd <= r_cmd_vld;
      if (r_cmd_vld) begin
        r_upd_addr <= r_cmd_addr;
      end
      r_q <= w_q_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign upd      = r_upd;
  assign upd_addr = r_upd_addr;
  assign Q        = r_q;
  assign Qm       = ~r_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (N_REQ=4, WIDTH=6, AW=3); honours JK_ARB_FIXED_PRIO_EN.
module tb_jk_bank_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 6;
  localparam int AW    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req, J, K;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ-1:0]    gnt;
  logic                upd;
  logic [AW-1:0]       upd_addr;
  logic [WIDTH-1:0]    Q, Qm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .J(J), .K(K), .addr(addr),
    .gnt(gnt), .upd(upd), .upd_addr(upd_addr), .Q(Q), .Qm(Qm)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  j;
    logic [3:0]  k;
    logic [11:0] addr;
    logic [3:0]  e_gnt;
    logic        e_upd;
    logic [2:0]  e_ua;
    logic [5:0]  e_q;
  } vec_t;

  vec_t tv[$];

  function automatic logic [11:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] j,
                              input logic [3:0] k, input logic [11:0] a, input logic [3:0] eg,
                              input logic eu, input int ua, input logic [5:0] eq);
    vec_t v;
    v.rst = r; v.req = rq; v.j = j; v.k = k; v.addr = a;
    v.e_gnt = eg; v.e_upd = eu; v.e_ua = 3'(ua); v.e_q = eq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic eu,
                           input logic [2:0] ua, input logic [5:0] eq);
    logic [5:0] eqm;
    eqm = ~eq;
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_upd"}, 32'(upd), 32'(eu));
    if (eu) chk({tag, "_upd_addr"}, 32'(upd_addr), 32'(ua));
    chk({tag, "_q"}, 32'(Q), 32'(eq));
    chk({tag, "_qm"}, 32'(Qm), 32'(eqm));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; J = '0; K = '0; addr = '0;
    step();
    step();
    check_out("rst", 4'b0, 1'b0, 3'd0, 6'h00);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_w;
    int w;
    logic [5:0] exp_q;
    logic [3:0] exp_g;

    rst = 1'b1; req = '0; J = '0; K = '0; addr = '0;

    // Reset with random traffic on the inputs.
    for (int c = 0; c < 3; c++) begin
      req  = 4'($urandom);
      J    = 4'($urandom);
      K    = 4'($urandom);
      addr = 12'($urandom);
      step();
      check_out($sformatf("reset_c%0d", c), 4'b0, 1'b0, 3'd0, 6'h00);
    end
    rst = 1'b0; req = 4'b1010; J = '0; K = '0; addr = pa(0, 2, 0, 4);
    step();
    check_out("first_grant", 4'b0010, 1'b0, 3'd0, 6'h00);
    req = 4'b1000;
    step();
    check_out("second_grant", 4'b1000, 1'b1, 3'd2, 6'h00);
    req = '0;
    step();

    // Table: single command, pointer position, hold/out-of-range, same-address ordering.
    tv.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, pa(0,0,0,0), 4'b0000, 0, 0, 6'h00));
    tv.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, pa(0,0,0,0), 4'b0000, 0, 0, 6'h00));
    tv.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, pa(0,0,5,0), 4'b0100, 0, 0, 6'h00));
    tv.push_back(mk(0, 4'b0000, 4'b0100, 4'b0000, pa(0,0,5,0), 4'b0000, 1, 5, 6'h20));
    tv.push_back(mk(0, 4'b0000, 4'b0100, 4'b0000, pa(0,0,5,0), 4'b0000, 0, 0, 6'h20));
`ifdef JK_ARB_FIXED_PRIO_EN
    tv.push_back(mk(0, 4'b1001, 4'b1001, 4'b0000, pa(2,0,0,4), 4'b0001, 0, 0, 6'h20));
    tv.push_back(mk(0, 4'b1000, 4'b1001, 4'b0000, pa(2,0,0,4), 4'b1000, 1, 2, 6'h24));
    tv.push_back(mk(0, 4'b0000, 4'b1001, 4'b0000, pa(2,0,0,4), 4'b0000, 1, 4, 6'h34));
`else
    tv.push_back(mk(0, 4'b1001, 4'b1001, 4'b0000, pa(2,0,0,4), 4'b1000, 0, 0, 6'h20));
    tv.push_back(mk(0, 4'b0001, 4'b1001, 4'b0000, pa(2,0,0,4), 4'b0001, 1, 4, 6'h30));
    tv.push_back(mk(0, 4'b0000, 4'b1001, 4'b0000, pa(2,0,0,4), 4'b0000, 1, 2, 6'h34));
`endif
    tv.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, pa(0,0,0,0), 4'b0000, 0, 0, 6'h34));
    tv.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, pa(0,0,0,0), 4'b0000, 0, 0, 6'h00));
    tv.push_back(mk(0, 4'b0001, 4'b0101, 4'b0000, pa(1,1,7,0), 4'b0001, 0, 0, 6'h00));
    tv.push_back(mk(0, 4'b0000, 4'b0101, 4'b0000, pa(1,1,7,0), 4'b0000, 1, 1, 6'h02));
    tv.push_back(mk(0, 4'b0010, 4'b0101, 4'b0000, pa(1,1,7,0), 4'b0010, 0, 0, 6'h02));
    tv.push_back(mk(0, 4'b0100, 4'b0101, 4'b0000, pa(1,1,7,0), 4'b0100, 1, 1, 6'h02));
    tv.push_back(mk(0, 4'b0000, 4'b0101, 4'b0000, pa(1,1,7,0), 4'b0000, 1, 7, 6'h02));
    tv.push_back(mk(0, 4'b0000, 4'b0101, 4'b0000, pa(1,1,7,0), 4'b0000, 0, 0, 6'h02));
    tv.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, pa(0,0,0,0), 4'b0000, 0, 0, 6'h00));
    tv.push_back(mk(0, 4'b0011, 4'b0011, 4'b0010, pa(3,3,0,0), 4'b0001, 0, 0, 6'h00));
    tv.push_back(mk(0, 4'b0010, 4'b0011, 4'b0010, pa(3,3,0,0), 4'b0010, 1, 3, 6'h08));
    tv.push_back(mk(0, 4'b0000, 4'b0011, 4'b0010, pa(3,3,0,0), 4'b0000, 1, 3, 6'h00));
    tv.push_back(mk(0, 4'b0000, 4'b0011, 4'b0010, pa(3,3,0,0), 4'b0000, 0, 0, 6'h00));

    foreach (tv[i]) begin
      rst = tv[i].rst; req = tv[i].req; J = tv[i].j; K = tv[i].k; addr = tv[i].addr;
      step();
      check_out($sformatf("row%0d", i), tv[i].e_gnt, tv[i].e_upd, tv[i].e_ua, tv[i].e_q);
    end

    // All four requesting continuously, each toggling its own cell.
    do_reset();
    req = 4'b1111; J = 4'b1111; K = 4'b1111; addr = pa(0, 1, 2, 3);
    exp_q  = 6'h00;
    prev_w = -1;
    for (int c = 0; c < 12; c++) begin
      step();
`ifdef JK_ARB_FIXED_PRIO_EN
      w = c % 2;
`else
      w = c % 4;
`endif
      if (prev_w >= 0) exp_q[prev_w] = ~exp_q[prev_w];
      exp_g = 4'b0001 << w;
      chk($sformatf("fair_c%0d_gnt", c), 32'(gnt), 32'(exp_g));
      chk($sformatf("fair_c%0d_upd", c), 32'(upd), (prev_w >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("fair_c%0d_q", c), 32'(Q), 32'(exp_q));
      prev_w = w;
    end
    req = '0;
    step();
    step();

    // Reset lands in the grant cycle: the captured set must be dropped.
    do_reset();
    req = 4'b0001; J = 4'b0001; K = 4'b0000; addr = pa(0, 0, 0, 0);
    step();
    check_out("midrst_gnt", 4'b0001, 1'b0, 3'd0, 6'h00);
    rst = 1'b1; req = '0;
    step();
    check_out("midrst_in", 4'b0000, 1'b0, 3'd0, 6'h00);
    rst = 1'b0;
    step();
    check_out("midrst_after1", 4'b0000, 1'b0, 3'd0, 6'h00);
    step();
    check_out("midrst_after2", 4'b0000, 1'b0, 3'd0, 6'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
